// File: rtl/dma_ram_rd_arb.sv
// Segmented DMA RAM read arbiter: per-segment round-robin command arbitration
// with an in-order routing FIFO that steers RAM read responses back to their requester.
module dma_ram_rd_arb #(
  parameter int PORTS          = 2,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int RAM_SEL_WIDTH  = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [PORTS*SEG_COUNT*RAM_SEL_WIDTH-1:0]  s_rd_cmd_sel_i,
  input  logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0] s_rd_cmd_addr_i,
  input  logic [PORTS*SEG_COUNT-1:0]                s_rd_cmd_valid_i,
  output logic [PORTS*SEG_COUNT-1:0]                s_rd_cmd_ready_o,
  output logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0] s_rd_resp_data_o,
  output logic [PORTS*SEG_COUNT-1:0]                s_rd_resp_valid_o,
  input  logic [PORTS*SEG_COUNT-1:0]                s_rd_resp_ready_i,
  output logic [SEG_COUNT*RAM_SEL_WIDTH-1:0]        m_rd_cmd_sel_o,
  output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]       m_rd_cmd_addr_o,
  output logic [SEG_COUNT-1:0]                      m_rd_cmd_valid_o,
  input  logic [SEG_COUNT-1:0]                      m_rd_cmd_ready_i,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]       m_rd_resp_data_i,
  input  logic [SEG_COUNT-1:0]                      m_rd_resp_valid_i,
  output logic [SEG_COUNT-1:0]                      m_rd_resp_ready_o
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  function automatic logic [PW-1:0] rrIndex(input logic [PW-1:0] last, input int offset);
    int idx;
    idx = (int'(last) + 1 + offset) % PORTS;
    return PW'(idx);
  endfunction

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [PORTS-1:0]          reqValid;
    logic [PORTS-1:0]          cmdReady;
    logic [PORTS-1:0]          respReady;
    logic [PORTS-1:0]          respValid;
    logic [RAM_SEL_WIDTH-1:0]  reqSel  [PORTS];
    logic [SEG_ADDR_WIDTH-1:0] reqAddr [PORTS];

    logic [RAM_SEL_WIDTH-1:0]  cmdSel_q, cmdSel_d;
    logic [SEG_ADDR_WIDTH-1:0] cmdAddr_q, cmdAddr_d;
    logic                      cmdValid_q, cmdValid_d;
    logic [PW-1:0]             lastGrant_q, lastGrant_d;
    logic [PW-1:0]             fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]             wrPtr_q, wrPtr_d;
    logic [AW-1:0]             rdPtr_q, rdPtr_d;
    logic [CW-1:0]             count_q, count_d;

    logic [PW-1:0] grant;
    logic [PW-1:0] head;
    logic          anyReq;
    logic          load;
    logic          pop;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          mRespReady;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int IDX = p*SEG_COUNT + n;
      assign reqValid[p]  = s_rd_cmd_valid_i[IDX];
      assign reqSel[p]    = s_rd_cmd_sel_i[IDX*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
      assign reqAddr[p]   = s_rd_cmd_addr_i[IDX*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
      assign respReady[p] = s_rd_resp_ready_i[IDX];
      assign s_rd_cmd_ready_o[IDX]  = cmdReady[p];
      assign s_rd_resp_valid_o[IDX] = respValid[p];
      assign s_rd_resp_data_o[IDX*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] =
        m_rd_resp_data_i[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
    end

    // Round-robin search begins just after the previous winner.
    always_comb begin
      grant  = lastGrant_q;
      anyReq = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        if (!anyReq && reqValid[rrIndex(lastGrant_q, i)]) begin
          anyReq = 1'b1;
          grant  = rrIndex(lastGrant_q, i);
        end
      end
    end

    // Full check deliberately ignores a same-cycle pop to keep ready off the response path.
    always_comb begin
      fifoEmpty  = (count_q == '0);
      fifoFull   = (count_q == CW'(FIFO_DEPTH));
      load       = !rst_i && (!cmdValid_q || m_rd_cmd_ready_i[n]) && !fifoFull && anyReq;
      head       = fifoMem_q[rdPtr_q];
      mRespReady = !fifoEmpty && respReady[head];
      pop        = mRespReady && m_rd_resp_valid_i[n];

      for (int i = 0; i < PORTS; i++) begin
        cmdReady[i]  = load && (grant == PW'(i));
        respValid[i] = !fifoEmpty && m_rd_resp_valid_i[n] && (head == PW'(i));
      end

      cmdSel_d    = cmdSel_q;
      cmdAddr_d   = cmdAddr_q;
      cmdValid_d  = cmdValid_q;
      lastGrant_d = lastGrant_q;
      if (load) begin
        cmdSel_d    = reqSel[grant];
        cmdAddr_d   = reqAddr[grant];
        cmdValid_d  = 1'b1;
        lastGrant_d = grant;
      end else if (m_rd_cmd_ready_i[n]) begin
        cmdValid_d = 1'b0;
      end

      wrPtr_d = wrPtr_q + AW'(load);
      rdPtr_d = rdPtr_q + AW'(pop);
      count_d = count_q + CW'(load) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cmdSel_q    <= '0;
        cmdAddr_q   <= '0;
        cmdValid_q  <= 1'b0;
        lastGrant_q <= PW'(PORTS - 1);
        wrPtr_q     <= '0;
        rdPtr_q     <= '0;
        count_q     <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          fifoMem_q[i] <= '0;
        end
      end else begin
        cmdSel_q    <= cmdSel_d;
        cmdAddr_q   <= cmdAddr_d;
        cmdValid_q  <= cmdValid_d;
        lastGrant_q <= lastGrant_d;
        wrPtr_q     <= wrPtr_d;
        rdPtr_q     <= rdPtr_d;
        count_q     <= count_d;
        if (load) begin
          fifoMem_q[wrPtr_q] <= grant;
        end
      end
    end

    assign m_rd_cmd_sel_o[n*RAM_SEL_WIDTH +: RAM_SEL_WIDTH]    = cmdSel_q;
    assign m_rd_cmd_addr_o[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH] = cmdAddr_q;
    assign m_rd_cmd_valid_o[n]  = cmdValid_q;
    assign m_rd_resp_ready_o[n] = mRespReady;
  end

endmodule

// File: tb/tb_dma_ram_rd_arb.sv
// Bench for dma_ram_rd_arb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dma_ram_rd_arb;

  localparam int P  = 2;
  localparam int S  = 2;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int D  = 8;
  localparam int N  = P*S;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*SW-1:0] sCmdSel;
  logic [N*AW-1:0] sCmdAddr;
  logic [N-1:0]    sCmdValid;
  logic [N-1:0]    sCmdReady;
  logic [N*DW-1:0] sRespData;
  logic [N-1:0]    sRespValid;
  logic [N-1:0]    sRespReady;
  logic [S*SW-1:0] mCmdSel;
  logic [S*AW-1:0] mCmdAddr;
  logic [S-1:0]    mCmdValid;
  logic [S-1:0]    mCmdReady;
  logic [S*DW-1:0] mRespData;
  logic [S-1:0]    mRespValid;
  logic [S-1:0]    mRespReady;

  int checkCount = 0;
  int passCount  = 0;

  dma_ram_rd_arb #(
    .PORTS(P), .SEG_COUNT(S), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW),
    .RAM_SEL_WIDTH(SW), .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_rd_cmd_sel_i(sCmdSel), .s_rd_cmd_addr_i(sCmdAddr),
    .s_rd_cmd_valid_i(sCmdValid), .s_rd_cmd_ready_o(sCmdReady),
    .s_rd_resp_data_o(sRespData), .s_rd_resp_valid_o(sRespValid),
    .s_rd_resp_ready_i(sRespReady),
    .m_rd_cmd_sel_o(mCmdSel), .m_rd_cmd_addr_o(mCmdAddr),
    .m_rd_cmd_valid_o(mCmdValid), .m_rd_cmd_ready_i(mCmdReady),
    .m_rd_resp_data_i(mRespData), .m_rd_resp_valid_i(mRespValid),
    .m_rd_resp_ready_o(mRespReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic applyStimulus(input logic [N-1:0] cmdValid, input logic [7:0] addrBase,
                               input logic [1:0] selBase, input logic [S-1:0] cmdReady,
                               input logic [S-1:0] respValid, input logic [63:0] respBase,
                               input logic [N-1:0] respReady);
    for (int i = 0; i < N; i++) begin
      sCmdAddr[i*AW +: AW] = addrBase + 8'(i);
      sCmdSel[i*SW +: SW]  = selBase + 2'(i);
    end
    for (int n = 0; n < S; n++) mRespData[n*DW +: DW] = respBase + 64'(n);
    sCmdValid  = cmdValid;
    mCmdReady  = cmdReady;
    mRespValid = respValid;
    sRespReady = respReady;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
  endtask

  // Reference model: outstanding reads per segment kept as an ordered list of owner ports.
  logic          mValid [S] = '{default: 1'b0};
  logic [AW-1:0] mAddr  [S] = '{default: '0};
  logic [SW-1:0] mSel   [S] = '{default: '0};
  int            mLast  [S] = '{default: P-1};
  int            routeList [S][D];
  int            routeCnt  [S] = '{default: 0};

  int  winM  [S];
  int  headM [S];
  bit  loadM [S];
  bit  popM  [S];
  logic [N-1:0]    eCmdReady, eRespValid;
  logic [S-1:0]    eMRespReady, eMValid;
  logic [S*AW-1:0] eMAddr;
  logic [S*SW-1:0] eMSel;
  logic [N*DW-1:0] eData, eMask;

  always @(negedge clk) begin
    eCmdReady = '0; eRespValid = '0; eMRespReady = '0; eData = '0; eMask = '0;
    for (int n = 0; n < S; n++) begin
      winM[n] = -1;
      for (int k = 0; k < P; k++)
        if (winM[n] < 0 && sCmdValid[((mLast[n]+1+k)%P)*S+n]) winM[n] = (mLast[n]+1+k)%P;
      loadM[n] = !rst && (!mValid[n] || mCmdReady[n]) && routeCnt[n] < D && winM[n] >= 0;
      headM[n] = (routeCnt[n] > 0) ? routeList[n][0] : -1;
      if (headM[n] >= 0) eMRespReady[n] = sRespReady[headM[n]*S+n];
      popM[n] = eMRespReady[n] && mRespValid[n];
      eMValid[n]        = mValid[n];
      eMAddr[n*AW +: AW] = mAddr[n];
      eMSel[n*SW +: SW]  = mSel[n];
      for (int p = 0; p < P; p++) begin
        eCmdReady[p*S+n]  = loadM[n] && winM[n] == p;
        eRespValid[p*S+n] = headM[n] == p && mRespValid[n];
        eData[(p*S+n)*DW +: DW] = mRespData[n*DW +: DW];
        if (eRespValid[p*S+n]) eMask[(p*S+n)*DW +: DW] = '1;
      end
    end
    checkOutput("cyc_s_cmd_ready", sCmdReady, eCmdReady);
    checkOutput("cyc_m_cmd_valid", mCmdValid, eMValid);
    checkOutput("cyc_m_cmd_addr", mCmdAddr, eMAddr);
    checkOutput("cyc_m_cmd_sel", mCmdSel, eMSel);
    checkOutput("cyc_s_resp_valid", sRespValid, eRespValid);
    checkOutput("cyc_m_resp_ready", mRespReady, eMRespReady);
    checkOutput("cyc_s_resp_data", sRespData & eMask, eData & eMask);

    for (int n = 0; n < S; n++) begin
      if (rst) begin
        mValid[n] = 1'b0; mAddr[n] = '0; mSel[n] = '0; mLast[n] = P-1; routeCnt[n] = 0;
      end else begin
        if (popM[n]) begin
          for (int j = 0; j < D-1; j++) routeList[n][j] = routeList[n][j+1];
          routeCnt[n]--;
        end
        if (loadM[n]) begin
          routeList[n][routeCnt[n]] = winM[n];
          routeCnt[n]++;
          mValid[n] = 1'b1;
          mAddr[n]  = sCmdAddr[(winM[n]*S+n)*AW +: AW];
          mSel[n]   = sCmdSel[(winM[n]*S+n)*SW +: SW];
          mLast[n]  = winM[n];
        end else if (mCmdReady[n]) begin
          mValid[n] = 1'b0;
        end
      end
    end
  end

  logic [3:0] fairExp [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
  int accepted;

  initial begin
    applyStimulus('0, 8'h00, 2'd0, '0, '0, 64'h0, '0);
    stepCycle();
    stepCycle();
    rst = 1'b0;

    // Reset state: unsolicited response must stall
    applyStimulus('0, 8'h00, 2'd0, 2'b11, 2'b11, 64'h5, 4'b1111);
    sampleCycle();
    checkOutput("rst_m_cmd_valid", mCmdValid, 2'b00);
    checkOutput("rst_s_resp_valid", sRespValid, 4'b0000);
    checkOutput("rst_m_resp_ready", mRespReady, 2'b00);
    stepCycle();

    // Single command and response
    applyStimulus(4'b0001, 8'h10, 2'd1, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t1_s_cmd_ready", sCmdReady, 4'b0001);
    stepCycle();
    applyStimulus(4'b0000, 8'h10, 2'd1, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t1_m_cmd_valid", mCmdValid, 2'b01);
    checkOutput("t1_m_cmd_addr", mCmdAddr, 16'h0010);
    checkOutput("t1_m_cmd_sel", mCmdSel, 4'b0001);
    stepCycle();
    applyStimulus(4'b0000, 8'h10, 2'd1, 2'b11, 2'b01, 64'hA5A5, 4'b1111);
    sampleCycle();
    checkOutput("t1_s_resp_valid", sRespValid, 4'b0001);
    checkOutput("t1_s_resp_data", sRespData[63:0], 64'hA5A5);
    checkOutput("t1_m_resp_ready", mRespReady, 2'b01);
    stepCycle();
    sampleCycle();
    checkOutput("t1_fifo_empty", mRespReady, 2'b00);
    checkOutput("t1_no_valid", sRespValid, 4'b0000);
    stepCycle();

    // Fairness on seg 0
    applyStimulus(4'b0101, 8'h20, 2'd0, 2'b11, 2'b01, 64'h100, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      sampleCycle();
      checkOutput("t2_grant", sCmdReady, fairExp[k]);
      stepCycle();
    end
    checkOutput("t2_seg1_idle", {mCmdValid[1], mCmdAddr[15:8], mCmdSel[3:2]}, 11'h0);
    applyStimulus(4'b0000, 8'h20, 2'd0, 2'b11, 2'b01, 64'h100, 4'b1111);
    repeat (3) stepCycle();

    // Ordering
    applyStimulus(4'b0100, 8'h0A, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t3_grant_p1", sCmdReady, 4'b0100);
    stepCycle();
    applyStimulus(4'b0001, 8'h0B, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t3_grant_p0", sCmdReady, 4'b0001);
    stepCycle();
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b01, 64'h11, 4'b1111);
    sampleCycle();
    checkOutput("t3_first_valid", sRespValid, 4'b0100);
    checkOutput("t3_first_data", sRespData[191:128], 64'h11);
    stepCycle();
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b01, 64'h22, 4'b1111);
    sampleCycle();
    checkOutput("t3_second_valid", sRespValid, 4'b0001);
    checkOutput("t3_second_data", sRespData[63:0], 64'h22);
    stepCycle();

    // FIFO full on seg 1
    accepted = 0;
    applyStimulus(4'b0010, 8'h40, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    for (int k = 0; k < 12; k++) begin
      sampleCycle();
      accepted += int'(sCmdReady[1]);
      stepCycle();
    end
    checkOutput("t4_accepted", accepted, 8);
    applyStimulus(4'b0010, 8'h40, 2'd0, 2'b11, 2'b10, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t4_full_pop_cycle", sCmdReady, 4'b0000);
    checkOutput("t4_pop_ready", mRespReady, 2'b10);
    stepCycle();
    applyStimulus(4'b0010, 8'h40, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t4_after_pop", sCmdReady, 4'b0010);
    stepCycle();
    applyStimulus(4'b0000, 8'h40, 2'd0, 2'b11, 2'b10, 64'h0, 4'b1111);
    repeat (9) stepCycle();

    // Backpressure on seg 1
    applyStimulus(4'b0010, 8'h50, 2'd0, 2'b00, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t5_load", sCmdReady, 4'b0010);
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 8'h60 + 8'(k), 2'd0, 2'b00, 2'b00, 64'h0, 4'b1111);
      sampleCycle();
      checkOutput("t5_no_ready", sCmdReady, 4'b0000);
      checkOutput("t5_addr_hold", mCmdAddr[15:8], 8'h51);
      checkOutput("t5_valid_hold", mCmdValid[1], 1'b1);
      stepCycle();
    end
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    stepCycle();
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b10, 64'h77, 4'b1101);
    sampleCycle();
    checkOutput("t5_resp_stall", mRespReady, 2'b00);
    checkOutput("t5_resp_shown", sRespValid, 4'b0010);
    stepCycle();
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b10, 64'h77, 4'b1111);
    sampleCycle();
    checkOutput("t5_resp_release", mRespReady, 2'b10);
    checkOutput("t5_resp_data", sRespData[127:64], 64'h78);
    stepCycle();

    // Reset with three reads outstanding on seg 0
    applyStimulus(4'b0001, 8'h30, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    repeat (3) stepCycle();
    rst = 1'b1;
    applyStimulus(4'b0000, 8'h30, 2'd0, 2'b11, 2'b11, 64'h0, 4'b1111);
    stepCycle();
    sampleCycle();
    checkOutput("t6_m_cmd_valid", mCmdValid, 2'b00);
    checkOutput("t6_s_resp_valid", sRespValid, 4'b0000);
    checkOutput("t6_m_resp_ready", mRespReady, 2'b00);
    stepCycle();
    rst = 1'b0;
    applyStimulus(4'b0101, 8'h30, 2'd0, 2'b11, 2'b00, 64'h0, 4'b1111);
    sampleCycle();
    checkOutput("t6_priority_p0", sCmdReady, 4'b0001);
    stepCycle();

    // Mixed traffic on both segments, covered by the per-cycle model
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'(i*7 + (i >> 2)), 8'(i*3), 2'(i), 2'((i % 4 == 0) ? 1 : 3),
                    2'(i ^ (i >> 1)), 64'(i*256), ~4'((i % 5 == 0) ? 5 : 0));
      stepCycle();
    end
    applyStimulus(4'b0000, 8'h00, 2'd0, 2'b11, 2'b11, 64'h0, 4'b1111);
    repeat (12) stepCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dma_ram_rd_arb.md
# dma_ram_rd_arb

Multi-port read arbiter for the segmented DMA RAM interface. It shares one segmented RAM read port among PORTS DMA requesters. Each segment has its own round-robin arbiter, a registered command stage and an in-order response routing FIFO. It sits between several DMA read clients and a single RAM, or a dma_ram_demux_rd-style fan-out, on the ctrl side of the RAM interface.

## Interface
- PORTS, 2: number of requester ports (≥2).
- SEG_COUNT, 2: RAM segments, each arbitrated independently.
- SEG_DATA_WIDTH, 64: segment data width.
- SEG_ADDR_WIDTH, 8: segment address width.
- RAM_SEL_WIDTH, 2: RAM select width, passed through unchanged.
- FIFO_DEPTH, 8: outstanding reads per segment (power of two).

Ports (requester p, segment n at index p*SEG_COUNT+n):
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_rd_cmd_sel  in  PORTS*SEG_COUNT*RAM_SEL_WIDTH  requester select.
- s_rd_cmd_addr  in  PORTS*SEG_COUNT*SEG_ADDR_WIDTH  requester address.
- s_rd_cmd_valid  in  PORTS*SEG_COUNT  command valid.
- s_rd_cmd_ready  out  PORTS*SEG_COUNT  command accepted.
- s_rd_resp_data  out  PORTS*SEG_COUNT*SEG_DATA_WIDTH  response data (broadcast of m data per segment).
- s_rd_resp_valid  out  PORTS*SEG_COUNT  response valid for owning port.
- s_rd_resp_ready  in  PORTS*SEG_COUNT  response ready.
- m_rd_cmd_sel  out  SEG_COUNT*RAM_SEL_WIDTH  RAM select.
- m_rd_cmd_addr  out  SEG_COUNT*SEG_ADDR_WIDTH  RAM address.
- m_rd_cmd_valid  out  SEG_COUNT  RAM command valid.
- m_rd_cmd_ready  in  SEG_COUNT  RAM command ready.
- m_rd_resp_data  in  SEG_COUNT*SEG_DATA_WIDTH  RAM response data.
- m_rd_resp_valid  in  SEG_COUNT  RAM response valid.
- m_rd_resp_ready  out  SEG_COUNT  RAM response ready.

## Operation
Everything below is per segment n. Segments share no state.
- **Command register:** one entry holding sel, addr, valid. It can load when it is empty or when m_rd_cmd_valid && m_rd_cmd_ready in the current cycle.
- **Load condition:** the register loads when it can load, the routing FIFO is not full, and at least one s_rd_cmd_valid[p] is high. The full check ignores a pop in the same cycle.
- **Arbitration:** round-robin. The search starts at last_grant+1 and wraps mod PORTS. Only the winner's s_rd_cmd_ready is high, and only in the load cycle. This path is combinational from s_rd_cmd_valid. last_grant updates to the winner on load.
- **Routing FIFO push:** on load, the winner's port index is pushed into the routing FIFO (depth FIFO_DEPTH, width clog2(PORTS)).
- **Response routing:** while the FIFO is non-empty, head port h gets s_rd_resp_valid[h] = m_rd_resp_valid, and m_rd_resp_ready = s_rd_resp_ready[h]. All other ports see valid 0. The FIFO pops on an m response handshake.
- **Empty FIFO:** m_rd_resp_ready is 0 and no s_rd_resp_valid is asserted. An unsolicited response stalls and is never dropped.
- **Ordering:** per segment, responses are delivered in command-issue order.
- **Pass-through:** sel and addr pass through unmodified. Data is not stored and goes straight through combinationally.

## Timing
- **Reset values:** m_rd_cmd_valid=0, s_rd_resp_valid=0, s_rd_cmd_ready=0, m_rd_resp_ready=0. FIFO empty. last_grant=PORTS-1, so port 0 has first priority. Data outputs are don't-care but must be deterministic (registers cleared to 0).
- **Command latency:** 1 cycle. An s handshake in cycle t gives m_rd_cmd_valid in t+1.
- **Throughput:** one command per cycle per segment while m_rd_cmd_ready=1 and the FIFO is not full.
- **Command hold:** m_rd_cmd_* stays stable while valid && !ready.
- **Response latency:** 0 cycles (combinational).
- **Simultaneous push and pop:** the count is unchanged. Pointers wrap mod FIFO_DEPTH. A full/empty distinction is required (count or extra pointer bit).
- **Reset mid-operation:** the command register and FIFO are discarded. Responses already in flight at the RAM are not tracked. The system must reset the RAM side concurrently.

## Test plan
- **Single command and response:** after reset, port 0 seg 0 issues addr 0x10, sel 1, with m_rd_cmd_ready=1. Required: s_rd_cmd_ready[0]=1 the same cycle, then next cycle m_rd_cmd_valid[0]=1, addr 0x10, sel 1. Then m_rd_resp_data=0xA5A5 → only port 0 seg 0 sees valid with 0xA5A5, and the FIFO empties.
- **Fairness:** ports 0 and 1 both hold valid on seg 0 continuously with m_rd_cmd_ready=1 and responses returned each cycle. Required: grants alternate 0,1,0,1. Seg 1 idle → its outputs stay 0.
- **Ordering:** port 1 issues A, then port 0 issues B. RAM returns 0x11 then 0x22. Required: 0x11 goes to port 1, then 0x22 to port 0.
- **FIFO full:** FIFO_DEPTH=8 and no responses returned. Required: 8 commands accepted, then s_rd_cmd_ready stays 0. After one response pop, the next command is accepted the following cycle.
- **Backpressure:**
  - m_rd_cmd_ready=0 for 5 cycles → m_rd_cmd_* is held stable and no further s_rd_cmd_ready is given.
  - Head port s_rd_resp_ready=0 → m_rd_resp_ready=0 and the FIFO count is unchanged.
- **Reset mid-operation:** assert rst with 3 commands outstanding. Required: the next cycle all valids are 0 and the FIFO is empty. After release, port 0 has priority.
